recip_sched: RTL and testbench
==============================

Name: recip_sched

Overview:
- Sequences and shares one combinational 8-bit `reciprocal` instance among NUM_REQ requesters in the bfloat16 datapath, e.g. divide and normalise stages.
- Round-robin arbitration with a valid/ready handshake on each requester.
- Drives the reciprocal operand and waits a programmable settle time.
- Captures the result and returns it tagged with the requester ID.
- Zero operands bypass the unit and return a flagged saturated result.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must equal ceil(log2(NUM_REQ)).
- SETTLE_CYCLES, 1, cycles the operand is held on recip_a before recip_r is sampled (1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*8  operands, requester i at bits [8i+7:8i], Q1.7.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  1  result valid.
- rsp_data  out  8  reciprocal result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_err  out  1  operand was zero.
- rsp_ready  in  1  consumer accepts the result.
- recip_a  out  8  operand to the reciprocal unit.
- recip_r  in  8  result from the reciprocal unit.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, rr_ptr=0, state=IDLE, op/id/cnt registers 0. Reset is asynchronous and may occur in any state.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - req_ready depends on req_valid; requesters must not make valid depend on ready.
  - On that clock edge: op_reg<=req_data[g], id_reg<=g, rr_ptr<=(g+1) mod NUM_REQ, cnt<=SETTLE_CYCLES, state<=WAIT.
  - With no valid request, stay in IDLE and leave rr_ptr unchanged.
- WAIT:
  - recip_a=op_reg (registered output, stable for the whole WAIT).
  - cnt decrements each cycle.
  - On the edge where cnt==1: rsp_data<=recip_r, rsp_id<=id_reg, rsp_err<=0, rsp_valid<=1, state<=RESP.
  - Latency from the accept edge to rsp_valid rising is exactly SETTLE_CYCLES cycles.
- Zero operand (op_reg==8'h00):
  - Latency and timing are identical to a normal operand.
  - rsp_data<=8'hFF and rsp_err<=1; recip_r is ignored.
- RESP:
  - rsp_valid, rsp_data, rsp_id and rsp_err are held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid<=0, state<=IDLE.
  - A new grant can occur in the cycle after the handshake. Peak throughput is one result per SETTLE_CYCLES+2 cycles.
- rsp_ready while rsp_valid=0 is ignored.
- Requests arriving in WAIT or RESP get no ready. They are evaluated in the next IDLE cycle under the current rr_ptr.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- Reset mid-WAIT or mid-RESP:
  - The in-flight result is discarded.
  - The owning requester has already seen its ready, so it must re-issue.
  - rr_ptr returns to 0.
- recip_a keeps its last operand in IDLE and RESP, so the unit does not toggle needlessly.
- busy=1 in WAIT and RESP.

Decomposition:
- Package recip_pkg holds:
  - the state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the operand width constant RECIP_W=8;
  - RECIP_SAT=8'hFF;
  - RECIP_ZERO=8'h00.
- One sub-module, rr_arbiter (NUM_REQ parameter): inputs req and ptr, outputs one-hot grant, grant index and any_req. Purely combinational.
- The FSM, counter and registers stay in recip_sched.
- The bench instantiates `reciprocal` and connects it to recip_a/recip_r.

Test Plan:
- Single request, SETTLE_CYCLES=1:
  - Stimulus: req_valid=4'b0001, operand 8'h40, rsp_ready=1.
  - Response: req_ready[0] pulses one cycle; rsp_valid rises 1 cycle after accept; rsp_id=0; rsp_err=0; rsp_data equals the reciprocal of 8'h40; busy falls the cycle after the handshake.
- Round robin:
  - Stimulus: all four requesters valid continuously with operands 8'h20, 8'h40, 8'h60, 8'h80.
  - Response: rsp_id sequence 0,1,2,3,0; each rsp_data matches the standalone reciprocal of its operand.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid rises, with operand 8'hC0.
  - Response: rsp_data, rsp_id and rsp_valid stable for all 5 cycles; no req_ready asserted meanwhile; exactly one response delivered.
- Zero operand:
  - Stimulus: requester 2 sends 8'h00.
  - Response: rsp_data=8'hFF, rsp_err=1, rsp_id=2, same latency as a normal operand.
- Settle latency:
  - Stimulus: SETTLE_CYCLES=3, operand 8'h78.
  - Response: recip_a=8'h78 stable for 3 cycles; rsp_valid rises exactly 3 cycles after the accept edge.
- Reset mid-operation:
  - Stimulus: rst_n low for 1 cycle while in WAIT.
  - Response: rsp_valid=0 and busy=0 immediately (asynchronous); next grant goes to the lowest valid index (rr_ptr=0).

Source files
------------

// File: rtl/recip_pkg.sv
// Shared types and constants for the reciprocal scheduler.
// State encoding plus operand width and special operand/result codes.
package recip_pkg;

  localparam int RECIP_W = 8;
  localparam logic [RECIP_W-1:0] RECIP_SAT = 8'hFF;
  localparam logic [RECIP_W-1:0] RECIP_ZERO = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/recip_sched_if.sv
// Requester and response handshake bundle for recip_sched.
// master = requesters/consumer side, slave = scheduler side.
interface recip_sched_if
  import recip_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*RECIP_W-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic rsp_valid;
  logic [RECIP_W-1:0] rsp_data;
  logic [ID_W-1:0] rsp_id;
  logic rsp_err;
  logic rsp_ready;

  modport master (
    output req_valid, req_data, rsp_ready,
    input req_ready, rsp_valid, rsp_data,
    input rsp_id, rsp_err
  );

  modport slave (
    input req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_id, rsp_err
  );

endinterface

// File: rtl/recip_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, wrapping.
// Purely combinational; grant is one-hot.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  logic found;
  int unsigned idx;

  // rotate the search start to ptr and take the first hit
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    idx = 0;
    any_req = |req;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant[idx] = 1'b1;
        grant_idx = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/reciprocal.sv
// Combinational reciprocal: Q1.7 operand in, Q4.4 result out.
// Result saturates to all-ones on overflow and on a zero operand.
module reciprocal (
  input  logic [7:0] a,
  output logic [7:0] r
);

  logic [11:0] q;

  // 1/x = 2048/a in Q4.4 when a is Q1.7
  always_comb begin
    q = '0;
    r = 8'hFF;
    if (a != 8'h00) begin
      q = 12'd2048 / {4'd0, a};
      r = (q > 12'd255) ? 8'hFF : q[7:0];
    end
  end

endmodule

// File: rtl/recip_sched.sv
// Shares one reciprocal unit among NUM_REQ requesters.
// Round-robin grant, settle wait, tagged held response.
module recip_sched
  import recip_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  recip_sched_if.slave       bus,
  output logic [RECIP_W-1:0] recip_a,
  input  logic [RECIP_W-1:0] recip_r,
  output logic               busy
);

  state_e state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [RECIP_W-1:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [RECIP_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] g_idx;
  logic any_req;
  logic [RECIP_W-1:0] op_sel;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W(ID_W)
  ) u_arb (
    .req(bus.req_valid),
    .ptr(rr_q),
    .grant(grant),
    .grant_idx(g_idx),
    .any_req(any_req)
  );

  assign op_sel = bus.req_data[g_idx*RECIP_W +: RECIP_W];

  // ready only while idle and out of reset
  assign bus.req_ready =
    (state_q == IDLE && rst_n) ? grant : '0;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_err = rsp_err_q;
  assign recip_a = op_q;
  assign busy = (state_q != IDLE);

  // next-state: accept, settle countdown, hold response
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    op_d = op_q;
    cnt_d = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d = rsp_id_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          op_d = op_sel;
          id_d = g_idx;
          rr_d = (g_idx == ID_W'(NUM_REQ - 1))
               ? '0 : g_idx + 1'b1;
          cnt_d = 4'(SETTLE_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_valid_d = 1'b1;
          rsp_id_d = id_q;
          if (op_q == RECIP_ZERO) begin
            rsp_data_d = RECIP_SAT;
            rsp_err_d = 1'b1;
          end else begin
            rsp_data_d = recip_r;
            rsp_err_d = 1'b0;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      op_q <= '0;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q <= rsp_id_d;
      rsp_err_q <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_recip_sched.sv
// Bench for recip_sched: settle 1 and settle 3 instances side by side.
// Shared stimulus, per-cycle reference model, directed sequences.
module tb_recip_sched;
  import recip_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid;
  logic [N*8-1:0] req_data;
  logic rsp_ready;

  recip_sched_if #(.NUM_REQ(N), .ID_W(2)) if1 ();
  recip_sched_if #(.NUM_REQ(N), .ID_W(2)) if3 ();

  assign if1.req_valid = req_valid;
  assign if1.req_data = req_data;
  assign if1.rsp_ready = rsp_ready;
  assign if3.req_valid = req_valid;
  assign if3.req_data = req_data;
  assign if3.rsp_ready = rsp_ready;

  logic [7:0] a1, r1, a3, r3;
  logic busy1, busy3;

  reciprocal u_rc1 (.a(a1), .r(r1));
  reciprocal u_rc3 (.a(a3), .r(r3));

  recip_sched #(
    .NUM_REQ(N), .ID_W(2), .SETTLE_CYCLES(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1),
    .recip_a(a1), .recip_r(r1), .busy(busy1)
  );

  recip_sched #(
    .NUM_REQ(N), .ID_W(2), .SETTLE_CYCLES(3)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3),
    .recip_a(a3), .recip_r(r3), .busy(busy3)
  );

  logic [N-1:0] o_rdy [2];
  logic o_rv [2];
  logic [7:0] o_rd [2];
  logic [1:0] o_rid [2];
  logic o_err [2];
  logic [7:0] o_a [2];
  logic o_busy [2];

  assign o_rdy[0] = if1.req_ready;
  assign o_rdy[1] = if3.req_ready;
  assign o_rv[0] = if1.rsp_valid;
  assign o_rv[1] = if3.rsp_valid;
  assign o_rd[0] = if1.rsp_data;
  assign o_rd[1] = if3.rsp_data;
  assign o_rid[0] = if1.rsp_id;
  assign o_rid[1] = if3.rsp_id;
  assign o_err[0] = if1.rsp_err;
  assign o_err[1] = if3.rsp_err;
  assign o_a[0] = a1;
  assign o_a[1] = a3;
  assign o_busy[0] = busy1;
  assign o_busy[1] = busy3;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // 1/x with x in Q1.7 and result in Q4.4, saturated
  function automatic logic [7:0] ref_recip(input logic [7:0] a);
    int q;
    if (a == 8'h00) return 8'hFF;
    q = 2048 / int'(a);
    return (q > 255) ? 8'hFF : 8'(q);
  endfunction

  // reference model: one job in flight, one held response
  int settle [2] = '{1, 3};
  bit m_job [2];
  int m_left [2];
  logic [7:0] m_op [2];
  int m_id [2];
  bit m_pend [2];
  logic [7:0] m_rd [2];
  int m_rid [2];
  bit m_rerr [2];
  logic [7:0] m_a [2];
  int m_rr [2];

  int acc_cyc [2];
  int rise_cyc [2];
  logic [7:0] rise_d [2];
  int rise_id [2];
  bit rise_err [2];
  logic [7:0] rise_a [2];
  bit prev_rv [2];

  typedef struct {
    int k;
    int id;
    logic [7:0] d;
  } rsp_t;
  rsp_t log_q [$];

  int g, ii;
  logic [N-1:0] er;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_job[k] = 0;
        m_pend[k] = 0;
        m_left[k] = 0;
        m_op[k] = 0;
        m_id[k] = 0;
        m_a[k] = 0;
        m_rr[k] = 0;
        prev_rv[k] = 0;
      end
      g = -1;
      er = '0;
      if (rst_n && !m_job[k] && !m_pend[k]) begin
        for (int j = 0; j < N; j++) begin
          ii = (m_rr[k] + j) % N;
          if (g < 0 && req_valid[ii]) g = ii;
        end
      end
      if (g >= 0) er[g] = 1'b1;
      check($sformatf("ready_k%0d", k), 32'(o_rdy[k]), 32'(er));
      check($sformatf("busy_k%0d", k), 32'(o_busy[k]),
            32'(m_job[k] || m_pend[k]));
      check($sformatf("rsp_valid_k%0d", k), 32'(o_rv[k]),
            32'(m_pend[k]));
      check($sformatf("recip_a_k%0d", k), 32'(o_a[k]),
            32'(m_a[k]));
      if (m_pend[k]) begin
        check($sformatf("rsp_data_k%0d", k), 32'(o_rd[k]),
              32'(m_rd[k]));
        check($sformatf("rsp_id_k%0d", k), 32'(o_rid[k]),
              32'(m_rid[k]));
        check($sformatf("rsp_err_k%0d", k), 32'(o_err[k]),
              32'(m_rerr[k]));
      end
      if (o_rdy[k] != '0) acc_cyc[k] = cyc;
      if (o_rv[k] && !prev_rv[k]) begin
        rise_cyc[k] = cyc;
        rise_d[k] = o_rd[k];
        rise_id[k] = int'(o_rid[k]);
        rise_err[k] = o_err[k];
        rise_a[k] = o_a[k];
      end
      prev_rv[k] = o_rv[k];
      if (rst_n && o_rv[k] && rsp_ready)
        log_q.push_back('{k, int'(o_rid[k]), o_rd[k]});
      if (rst_n) begin
        if (m_pend[k]) begin
          if (rsp_ready) m_pend[k] = 0;
        end else if (m_job[k]) begin
          if (m_left[k] == 1) begin
            m_job[k] = 0;
            m_pend[k] = 1;
            m_rd[k] = ref_recip(m_op[k]);
            m_rerr[k] = (m_op[k] == 8'h00);
            m_rid[k] = m_id[k];
          end else begin
            m_left[k] = m_left[k] - 1;
          end
        end else if (g >= 0) begin
          m_job[k] = 1;
          m_op[k] = req_data[g*8 +: 8];
          m_id[k] = g;
          m_left[k] = settle[k];
          m_a[k] = req_data[g*8 +: 8];
          m_rr[k] = (g + 1) % N;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((o_busy[0] || o_busy[1]) && t < 60) begin
      tick();
      t++;
    end
    check({nm, "_timeout"}, 32'(t >= 60), 0);
  endtask

  task automatic wait_busy(input string nm);
    int t;
    t = 0;
    while (!(o_busy[0] && o_busy[1]) && t < 20) begin
      tick();
      t++;
    end
    check({nm, "_timeout"}, 32'(t >= 20), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    int r;
    logic [7:0] op;
    logic [7:0] exp_d;
    bit exp_e;
  } vec_t;
  vec_t vt [8];

  int n1, t, cnt_id1;
  logic [7:0] hold_d;
  logic [1:0] hold_id;
  logic [7:0] ops [4];
  int exp_ids [5];

  initial begin
    vt[0] = '{0, 8'h40, 8'h20, 1'b0};
    vt[1] = '{1, 8'h20, 8'h40, 1'b0};
    vt[2] = '{2, 8'h00, 8'hFF, 1'b1};
    vt[3] = '{3, 8'h60, 8'h15, 1'b0};
    vt[4] = '{0, 8'h80, 8'h10, 1'b0};
    vt[5] = '{1, 8'hFF, 8'h08, 1'b0};
    vt[6] = '{3, 8'h01, 8'hFF, 1'b0};
    vt[7] = '{2, 8'h09, 8'hE3, 1'b0};
    ops = '{8'h20, 8'h40, 8'h60, 8'h80};
    exp_ids = '{0, 1, 2, 3, 0};

    req_valid = '1;
    req_data = '0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_rdy_k%0d", k), 32'(o_rdy[k]), 0);
      check($sformatf("rst_rv_k%0d", k), 32'(o_rv[k]), 0);
      check($sformatf("rst_rd_k%0d", k), 32'(o_rd[k]), 0);
      check($sformatf("rst_rid_k%0d", k), 32'(o_rid[k]), 0);
      check($sformatf("rst_err_k%0d", k), 32'(o_err[k]), 0);
      check($sformatf("rst_a_k%0d", k), 32'(o_a[k]), 0);
      check($sformatf("rst_busy_k%0d", k), 32'(o_busy[k]), 0);
    end
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // table: single requests on an idle scheduler
    for (int v = 0; v < 8; v++) begin
      rsp_ready = 1'b1;
      req_data[vt[v].r*8 +: 8] = vt[v].op;
      req_valid = N'(1) << vt[v].r;
      wait_busy($sformatf("vec%0d_acc", v));
      req_valid = '0;
      wait_idle($sformatf("vec%0d_done", v));
      for (int k = 0; k < 2; k++) begin
        check($sformatf("vec%0d_lat_k%0d", v, k),
              32'(rise_cyc[k] - acc_cyc[k] - 1), 32'(settle[k]));
        check($sformatf("vec%0d_data_k%0d", v, k),
              32'(rise_d[k]), 32'(vt[v].exp_d));
        check($sformatf("vec%0d_err_k%0d", v, k),
              32'(rise_err[k]), 32'(vt[v].exp_e));
        check($sformatf("vec%0d_id_k%0d", v, k),
              32'(rise_id[k]), 32'(vt[v].r));
        check($sformatf("vec%0d_a_k%0d", v, k),
              32'(rise_a[k]), 32'(vt[v].op));
      end
    end

    // round robin with all requesters continuously valid
    pulse_reset();
    for (int i = 0; i < N; i++) req_data[i*8 +: 8] = ops[i];
    log_q.delete();
    rsp_ready = 1'b1;
    req_valid = '1;
    n1 = 0;
    t = 0;
    while (n1 < 5 && t < 200) begin
      tick();
      t++;
      n1 = 0;
      foreach (log_q[i]) if (log_q[i].k == 0) n1++;
    end
    check("rr_timeout", 32'(t >= 200), 0);
    req_valid = '0;
    wait_idle("rr_done");
    n1 = 0;
    foreach (log_q[i]) begin
      if (log_q[i].k == 0 && n1 < 5) begin
        check($sformatf("rr_id%0d", n1), 32'(log_q[i].id),
              32'(exp_ids[n1]));
        check($sformatf("rr_data%0d", n1), 32'(log_q[i].d),
              32'(ref_recip(ops[exp_ids[n1]])));
        n1++;
      end
    end
    check("rr_count", 32'(n1), 5);

    // backpressure: hold the response for 5 cycles
    log_q.delete();
    rsp_ready = 1'b0;
    req_data[15:8] = 8'hC0;
    req_valid = 4'b0010;
    wait_busy("bp_acc");
    req_data[31:24] = 8'h33;
    req_valid = 4'b1000;
    t = 0;
    while (!o_rv[0] && t < 20) begin
      tick();
      t++;
    end
    check("bp_rise_timeout", 32'(t >= 20), 0);
    hold_d = o_rd[0];
    hold_id = o_rid[0];
    check("bp_data", 32'(hold_d), 32'h0A);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_rv%0d", c), 32'(o_rv[0]), 1);
      check($sformatf("bp_rd%0d", c), 32'(o_rd[0]), 32'(hold_d));
      check($sformatf("bp_id%0d", c), 32'(o_rid[0]), 32'(hold_id));
      check($sformatf("bp_rdy%0d", c), 32'(o_rdy[0]), 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("bp_done");
    n1 = 0;
    cnt_id1 = 0;
    foreach (log_q[i]) begin
      if (log_q[i].k == 0) begin
        n1++;
        if (log_q[i].id == 1) cnt_id1++;
      end
    end
    check("bp_one_rsp", 32'(n1), 1);
    check("bp_rsp_id1", 32'(cnt_id1), 1);

    // asynchronous reset while both are in WAIT
    req_data[23:16] = 8'h55;
    req_valid = 4'b0100;
    wait_busy("rst_acc");
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("arst_rv_k%0d", k), 32'(o_rv[k]), 0);
      check($sformatf("arst_busy_k%0d", k), 32'(o_busy[k]), 0);
    end
    tick();
    rst_n = 1'b1;
    req_valid = '1;
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("arst_grant_k%0d", k), 32'(o_rdy[k]), 1);
    tick();
    req_valid = '0;
    wait_idle("arst_done");

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++)
        req_data[i*8 +: 8] =
          ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("rand_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
